// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: two-port arbiter in front of a single-ported word memory.
// Each accepted request takes three cycles: IDLE (sample and latch), ACCESS
// (grant pulse and memory strobes) and RESP (rvalid pulse).
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to alternate the winner on
// simultaneous requests. When it is undefined, port 0 always wins a tie.
// Every output is forced low while rst is high. This keeps a reset that lands
// in an ACCESS cycle from issuing a store.
module mem_access_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        we0,
    input  logic [3:0]  addr0,
    input  logic [31:0] wdata0,
    output logic        gnt0,
    output logic        rvalid0,
    output logic [31:0] rdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [3:0]  addr1,
    input  logic [31:0] wdata1,
    output logic        gnt1,
    output logic        rvalid1,
    output logic [31:0] rdata1,
    output logic [3:0]  mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_ldr_str_en,
    output logic        mem_load_en,
    output logic        mem_store_en,
    input  logic [31:0] mem_read_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_win;
    logic        r_win;
    logic        r_we;
    logic [3:0]  r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;
    logic        w_access;
    logic        w_resp;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // r_last holds the most recently granted port. Reset value 1 gives port 0 the first tie.
    logic        r_last;

    // Tie goes to the port that was not granted last.
    assign w_win = (req0 && req1) ? ~r_last : ~req0;

    // Pointer tracks the port of each accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_win;
        end
    end
`else
    // Fixed priority: port 0 wins whenever it is requesting.
    assign w_win = ~req0;
`endif

    // Next-state logic: sample requests only in IDLE; ACCESS and RESP last one cycle each.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    w_state_nxt = ST_ACCESS;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the winner's command when a request is accepted; hold it otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 4'h0;
            r_wdata <= 32'h0;
        end else if (w_accept) begin
            r_win   <= w_win;
            r_we    <= w_win ? we1 : we0;
            r_addr  <= w_win ? addr1 : addr0;
            r_wdata <= w_win ? wdata1 : wdata0;
        end
    end

    // Capture load data into the winner's result register at the end of ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata0 <= 32'h0;
            r_rdata1 <= 32'h0;
        end else if ((r_state == ST_ACCESS) && !r_we) begin
            if (r_win) begin
                r_rdata1 <= mem_read_data;
            end else begin
                r_rdata0 <= mem_read_data;
            end
        end
    end

    assign w_access       = (r_state == ST_ACCESS) && !rst;
    assign w_resp         = (r_state == ST_RESP) && !rst;

    assign gnt0           = w_access && !r_win;
    assign gnt1           = w_access && r_win;
    assign rvalid0        = w_resp && !r_win;
    assign rvalid1        = w_resp && r_win;
    assign busy           = (r_state != ST_IDLE) && !rst;
    assign mem_ldr_str_en = w_access;
    assign mem_load_en    = w_access && !r_we;
    assign mem_store_en   = w_access && r_we;
    assign mem_addr       = rst ? 4'h0 : r_addr;
    assign mem_write_data = rst ? 32'h0 : r_wdata;
    assign rdata0         = rst ? 32'h0 : r_rdata0;
    assign rdata1         = rst ? 32'h0 : r_rdata1;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Testbench for mem_access_arbiter. A transaction-level reference model is
// checked against the DUT on every falling edge. Hand-computed directed
// scenarios pin the model, and randomized traffic follows them.
module tb_mem_access_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [3:0]  addr0 = 4'h0, addr1 = 4'h0;
    logic [31:0] wdata0 = 32'h0, wdata1 = 32'h0;
    logic        gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [31:0] rdata0, rdata1;
    logic [3:0]  mem_addr;
    logic [31:0] mem_write_data, mem_read_data;
    logic        mem_ldr_str_en, mem_load_en, mem_store_en;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mem_access_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_ldr_str_en(mem_ldr_str_en), .mem_load_en(mem_load_en),
        .mem_store_en(mem_store_en), .mem_read_data(mem_read_data),
        .busy(busy)
    );

    // The environment memory is initialised on the first clock edge.
    // Reset never clears it.
    logic [31:0] mem [16];
    logic        mem_ready = 1'b0;
    assign mem_read_data = mem[mem_addr];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'(i) * 32'h01010101;
            mem_ready <= 1'b1;
        end else if (mem_store_en) begin
            mem[mem_addr] <= mem_write_data;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // Arbitration rule for a request pair, given the port granted last.
    function automatic logic pick(input logic r0, input logic r1, input logic lastg);
        if (r0 && r1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return ~lastg;
`else
            return 1'b0 & lastg;
`endif
        end
        return r0 ? 1'b0 : 1'b1;
    endfunction

    // Reference model: one transaction in flight, described by its age
    // (0 = none, 1 = grant cycle, 2 = response cycle).
    int          m_age;
    logic        m_win, m_we, m_last;
    logic [3:0]  m_addr;
    logic [31:0] m_wdata, m_rd0, m_rd1;
    logic [31:0] ref_mem [16];
    logic [107:0] exp_v, act_v;

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'(i) * 32'h01010101;
        m_age = 0; m_win = 1'b0; m_we = 1'b0; m_last = 1'b1;
        m_addr = 4'h0; m_wdata = 32'h0; m_rd0 = 32'h0; m_rd1 = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_v = 108'h0;
            end else begin
                exp_v = {(m_age == 1) && !m_win, (m_age == 1) && m_win,
                         (m_age == 2) && !m_win, (m_age == 2) && m_win,
                         (m_age != 0), (m_age == 1),
                         (m_age == 1) && !m_we, (m_age == 1) && m_we,
                         m_addr, m_wdata, m_rd0, m_rd1};
            end
            act_v = {gnt0, gnt1, rvalid0, rvalid1, busy, mem_ldr_str_en,
                     mem_load_en, mem_store_en, mem_addr, mem_write_data, rdata0, rdata1};
            n_total++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL cycle_model got=%h want=%h at %0t", act_v, exp_v, $time);
            end
            // Advance the model over the coming rising edge.
            if (rst) begin
                m_age = 0; m_win = 1'b0; m_we = 1'b0; m_last = 1'b1;
                m_addr = 4'h0; m_wdata = 32'h0; m_rd0 = 32'h0; m_rd1 = 32'h0;
            end else if (m_age == 0) begin
                if (req0 || req1) begin
                    m_win   = pick(req0, req1, m_last);
                    m_we    = m_win ? we1 : we0;
                    m_addr  = m_win ? addr1 : addr0;
                    m_wdata = m_win ? wdata1 : wdata0;
                    m_last  = m_win;
                    m_age   = 1;
                end
            end else if (m_age == 1) begin
                if (m_we) ref_mem[m_addr] = m_wdata;
                else if (m_win) m_rd1 = ref_mem[m_addr];
                else m_rd0 = ref_mem[m_addr];
                m_age = 2;
            end else begin
                m_age = 0;
            end
        end
    end

    // One transaction on a port. Enter and leave at 2 time units after a rising edge,
    // with the DUT idle.
    task automatic tx(input int port, input logic we, input logic [3:0] a, input logic [31:0] d,
                      output int gl, output int rl, output logic [31:0] rd,
                      output logic [2:0] strb, output logic [3:0] ma);
        logic gs, vs;
        gl = 0; rl = 0; rd = 32'h0; strb = 3'b000; ma = 4'h0;
        if (port == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        else begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            gs = (port == 0) ? gnt0 : gnt1;
            vs = (port == 0) ? rvalid0 : rvalid1;
            if (gs) begin gl = k; strb = {mem_ldr_str_en, mem_load_en, mem_store_en}; ma = mem_addr; end
            if (vs) begin rl = k; rd = (port == 0) ? rdata0 : rdata1; end
            #1;
            if (gs) begin if (port == 0) req0 = 1'b0; else req1 = 1'b0; end
            if (vs) break;
        end
        if (rl == 0) begin
            n_total++; n_bad++;
            $display("FAIL tx_timeout port=%0d got=none want=rvalid", port);
            req0 = 1'b0; req1 = 1'b0;
        end
        @(posedge clk); #2;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gl, rl;
        logic [31:0] rd;
        logic [2:0]  strb;
        logic [3:0]  ma;
        logic [3:0]  order;
        int ng;
        logic g0, g1, rst_new;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_gnt", {30'h0, gnt0, gnt1}, 32'h0);
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_mem_addr", {28'h0, mem_addr}, 32'h0);
        #1 rst = 1'b0;

        // Store then load on port 0.
        tx(0, 1'b1, 4'd5, 32'hDEADBEEF, gl, rl, rd, strb, ma);
        check("st0_gnt_lat", gl, 32'd1);
        check("st0_rv_lat", rl, 32'd2);
        tx(0, 1'b0, 4'd5, 32'h0, gl, rl, rd, strb, ma);
        check("ld0_gnt_lat", gl, 32'd1);
        check("ld0_rv_lat", rl, 32'd2);
        check("ld0_rdata", rd, 32'hDEADBEEF);

        // Load on port 1, then a store on port 1 that must leave rdata1 alone.
        tx(1, 1'b0, 4'd2, 32'h0, gl, rl, rd, strb, ma);
        check("ld1_rdata", rd, 32'h02020202);
        tx(1, 1'b1, 4'd15, 32'h1, gl, rl, rd, strb, ma);
        check("st1_strobes", {29'h0, strb}, 32'h5);
        check("st1_mem_addr", {28'h0, ma}, 32'd15);
        check("st1_rdata_hold", rd, 32'h02020202);
        check("st1_rv_lat", rl, 32'd2);

        // Simultaneous held requests.
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd2;
        order = 4'h0; ng = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (gnt0 && ng < 4) begin order[ng] = 1'b0; ng++; end
            if (gnt1 && ng < 4) begin order[ng] = 1'b1; ng++; end
            #1;
        end
        req0 = 1'b0; req1 = 1'b0;
        check("tie_count", ng, 32'd4);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        check("tie_order", {28'h0, order}, 32'h0000000A);
`else
        check("tie_order", {28'h0, order}, 32'h0);
`endif
        @(posedge clk); #2;

        // Reset in the ACCESS cycle of a store to address 3.
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 32'hBAD0BAD0;
        @(posedge clk); #1;
        check("rmid_gnt", {31'h0, gnt0}, 32'h1);
        rst = 1'b1; req0 = 1'b0;
        #1;
        check("rmid_strobes", {29'h0, mem_ldr_str_en, mem_load_en, mem_store_en}, 32'h0);
        check("rmid_gnt_gated", {31'h0, gnt0}, 32'h0);
        @(posedge clk); #1;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("rmid_busy", {31'h0, busy}, 32'h0);
        check("rmid_rvalid", {31'h0, rvalid0}, 32'h0);
        check("rmid_mem3", mem[3], 32'h03030303);
        #1;

        // Idle: rdata must hold over ten quiet cycles.
        tx(0, 1'b0, 4'd7, 32'h0, gl, rl, rd, strb, ma);
        check("idle_ld", rd, 32'h07070707);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("idle_quiet", {24'h0, busy, mem_ldr_str_en, mem_load_en, mem_store_en,
                                 gnt0, gnt1, rvalid0, rvalid1}, 32'h0);
            check("idle_rdata0", rdata0, 32'h07070707);
            check("idle_rdata1", rdata1, 32'h0);
            #1;
        end

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            g0 = gnt0; g1 = gnt1;
            #1;
            rst_new = ($urandom_range(0, 99) == 0);
            if (req0 && g0 && !rst_new) begin
                if ($urandom_range(0, 3) != 0) req0 = 1'b0;
            end else if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1'b1; we0 = 1'($urandom_range(0, 1));
                addr0 = 4'($urandom_range(0, 15)); wdata0 = $urandom;
            end
            if (req1 && g1 && !rst_new) begin
                if ($urandom_range(0, 3) != 0) req1 = 1'b0;
            end else if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1'b1; we1 = 1'($urandom_range(0, 1));
                addr1 = 4'($urandom_range(0, 15)); wdata1 = $urandom;
            end
            rst = rst_new;
        end
        req0 = 1'b0; req1 = 1'b0; rst = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_arbiter.md
MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have, per port k in {0,1}: reqk  input  1  access request, held until gntk.
REQ-004 SHALL have, per port k: wek  input  1  1 = store, 0 = load; stable while reqk high.
REQ-005 SHALL have, per port k: addrk  input  4  word address; stable while reqk high.
REQ-006 SHALL have, per port k: wdatak  input  32  store data; stable while reqk high.
REQ-007 SHALL have, per port k: gntk  output  1  one-cycle pulse, request accepted.
REQ-008 SHALL have, per port k: rvalidk  output  1  one-cycle pulse, access complete.
REQ-009 SHALL have, per port k: rdatak  output  32  load result; valid when rvalidk follows a load.
REQ-010 SHALL have: mem_addr  output  4  memory word address.
REQ-011 SHALL have: mem_write_data  output  32  memory store data.
REQ-012 SHALL have: mem_ldr_str_en, mem_load_en, mem_store_en  output  1 each  memory access strobes.
REQ-013 SHALL have: mem_read_data  input  32  memory read data, combinational from mem_addr.
REQ-014 SHALL have: busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS and RESP; RESP SHALL always return to IDLE.
REQ-016 IDLE: if req0 or req1 is high at a rising edge, SHALL latch the winner's we, addr and wdata, record the winner, and enter ACCESS; otherwise SHALL stay in IDLE.
REQ-017 ACCESS (exactly 1 cycle): gnt of the winner SHALL be high; mem_ldr_str_en=1, mem_store_en=we, mem_load_en=!we; mem_addr and mem_write_data SHALL come from the latched values.
REQ-018 At the end of an ACCESS cycle for a load, the winner's rdata register SHALL capture mem_read_data; state SHALL then go to RESP.
REQ-019 RESP (exactly 1 cycle): the winner's rvalid SHALL be high for both loads and stores; all mem strobes SHALL be 0.
REQ-020 Latency: request sampled at edge N -> gnt in cycle N+1, rvalid in cycle N+2, IDLE in cycle N+3; peak throughput SHALL be one access per 3 cycles.
REQ-021 Requests SHALL be sampled only in IDLE; a req still high in IDLE after its rvalid SHALL be treated as a new request.
REQ-022 The non-winning port SHALL see no gnt or rvalid and SHALL keep its request pending.
REQ-023 rdatak SHALL hold its value until the next load completion on port k; store completions SHALL NOT alter rdatak.
REQ-024 In every non-ACCESS cycle, mem strobes SHALL be 0, and mem_addr and mem_write_data SHALL hold their last values.
REQ-025 Every gnt and rvalid output SHALL be 0 outside the single cycle defined for it.

Reset
REQ-026 While rst is high: state SHALL go to IDLE; every gnt, rvalid, strobe and busy output SHALL be 0; every rdata, mem_addr and mem_write_data output SHALL be 32'h0 / 4'h0; the priority pointer SHALL favour port 0.
REQ-027 Mem strobes SHALL be gated low combinationally in any cycle rst is high, so reset during ACCESS performs no store.
REQ-028 A transaction interrupted by reset SHALL be abandoned with no rvalid; requesters SHALL re-issue it.

Configuration
REQ-029 With macro MEM_ARB_ROUND_ROBIN_EN defined, on simultaneous requests the port not most recently granted SHALL win; the pointer SHALL update on each grant.
REQ-030 Without MEM_ARB_ROUND_ROBIN_EN, port 0 SHALL always win on simultaneous requests and there SHALL be no pointer state.

Verification
REQ-031 Store then load on port 0: store addr 4'd5, data 32'hDEADBEEF, then load addr 5 -> gnt0 at N+1, rvalid0 at N+2, rdata0=32'hDEADBEEF.
REQ-032 Simultaneous requests, round robin: req0 (load addr 1) and req1 (load addr 2) held high -> grants alternate 0,1,0,1; without the macro -> port 0 is granted every time.
REQ-033 Store on port 1: addr 4'd15, data 32'h1 -> in the gnt1 cycle mem_store_en=1, mem_load_en=0, mem_addr=15; rdata1 unchanged at rvalid1.
REQ-034 Reset mid-access: rst asserted in an ACCESS cycle of a store to addr 3 -> strobes 0 that cycle, no rvalid, memory addr 3 unchanged, busy=0 next cycle.
REQ-035 Idle behaviour: no requests for 10 cycles -> busy=0, all strobes, gnt and rvalid outputs 0, rdata outputs hold their values.
